dpic_mem_port: RTL and testbench

- Parametrised successor to the single-cycle DPI-C memory model: a handshaked, latency-modelling simulation memory port for the NPC.
- Accepts one request at a time over valid/ready, waits a configurable (optionally randomised) number of cycles, then performs the access through npc_pmem_read/npc_pmem_write.
- Returns read data or write acknowledgment, with an error flag, over a valid/ready response channel.
- Sits between the IFU/LSU bus masters and the DPI-C physical memory; supports 32- or 64-bit data.

---
 rtl/dpic_mem_port.sv | 205 ++++++++++++++++++++
 tb/tb_dpic_mem_port.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpic_mem_port.sv
// dpic_mem_port: handshaked, latency-modelling simulation memory port for the NPC.
// dpic_mem_pkg holds the npc_pmem_* physical-memory model that the port calls into.

package dpic_mem_pkg;

  // Sparse word store keyed by word address; unwritten words read as zero.
  logic [31:0] pmem_words [int unsigned];
  int unsigned pmem_rd_calls;
  int unsigned pmem_wr_calls;

  function automatic logic [31:0] npc_pmem_read(input logic [31:0] raddr);
    int unsigned key;
    key = raddr >> 2;
    pmem_rd_calls++;
    if (pmem_words.exists(key)) return pmem_words[key];
    return 32'h0;
  endfunction

  // Strobes [3:0] hit the addressed word, [7:4] the word after it.
  function automatic void npc_pmem_write(input logic [31:0] waddr, input logic [31:0] wdata,
                                         input logic [7:0] wmask);
    int unsigned key;
    logic [63:0] dword;
    logic [63:0] dnew;
    key = waddr >> 2;
    dword[31:0]  = pmem_words.exists(key) ? pmem_words[key] : 32'h0;
    dword[63:32] = pmem_words.exists(key + 1) ? pmem_words[key + 1] : 32'h0;
    dnew = {wdata, wdata};
    for (int i = 0; i < 8; i++) begin
      if (wmask[i]) dword[8*i +: 8] = dnew[8*i +: 8];
    end
    if (wmask[3:0] != 4'h0) pmem_words[key] = dword[31:0];
    if (wmask[7:4] != 4'h0) pmem_words[key + 1] = dword[63:32];
    pmem_wr_calls++;
  endfunction

endpackage

module dpic_mem_port
  import dpic_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned RAND_DELAY = 0,
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0800_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_wen,
  output logic                resp_err
);

  localparam int unsigned Bytes = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;

  logic [DATA_W-1:0]   rdata_q;
  logic                rsp_wen_q;
  logic                rsp_err_q;

  logic [31:0]         extra;
  logic                acc_fire;
  logic                acc_err;
  logic [31:0]         acc_addr;
  logic [63:0]         addr_ext;
  logic [63:0]         addr_algn;
  logic [63:0]         mem_end;

  assign extra    = (RAND_DELAY != 0) ? {29'h0, lfsr_q[2:0]} : 32'h0;
  assign acc_fire = (state_q == StWait) && (cnt_q == 32'h0);

  // Range check on the aligned address in 64 bits so base+size cannot wrap.
  always_comb begin
    addr_ext  = 64'(addr_q);
    addr_algn = addr_ext & ~64'(Bytes - 1);
    mem_end   = 64'(MEM_BASE) + 64'(MEM_SIZE);
    acc_err   = (addr_algn < 64'(MEM_BASE)) ||
                (addr_algn + 64'(Bytes) > mem_end) ||
                (addr_algn[63:32] != 32'h0);
  end

  assign acc_addr = addr_algn[31:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = LATENCY - 1 + extra;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 32'h0) state_d = StResp;
        else                cnt_d   = cnt_q - 32'h1;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lfsr_q  <= 8'hA5;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // Memory calls carry side effects, so they live in the clocked block and fire exactly once.
  if (DATA_W == 64) begin : gen_w64
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q   <= '0;
        rsp_wen_q <= 1'b0;
        rsp_err_q <= 1'b0;
      end else if (acc_fire) begin
        rsp_wen_q <= wen_q;
        rsp_err_q <= acc_err;
        if (acc_err) begin
          rdata_q <= '0;
        end else if (wen_q) begin
          if (wmask_q[3:0] != 4'h0) begin
            npc_pmem_write(acc_addr, wdata_q[31:0], {4'h0, wmask_q[3:0]});
          end
          if (wmask_q[7:4] != 4'h0) begin
            npc_pmem_write(acc_addr + 32'd4, wdata_q[63:32], {4'h0, wmask_q[7:4]});
          end
          rdata_q <= '0;
        end else begin
          rdata_q <= {npc_pmem_read(acc_addr + 32'd4), npc_pmem_read(acc_addr)};
        end
      end
    end
  end else begin : gen_w32
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q   <= '0;
        rsp_wen_q <= 1'b0;
        rsp_err_q <= 1'b0;
      end else if (acc_fire) begin
        rsp_wen_q <= wen_q;
        rsp_err_q <= acc_err;
        if (acc_err) begin
          rdata_q <= '0;
        end else if (wen_q) begin
          if (wmask_q != '0) npc_pmem_write(acc_addr, wdata_q, {4'h0, wmask_q});
          rdata_q <= '0;
        end else begin
          rdata_q <= npc_pmem_read(acc_addr);
        end
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_wen   = rsp_wen_q;
  assign resp_err   = rsp_err_q;

endmodule

// File: tb/tb_dpic_mem_port.sv
// Bench for dpic_mem_port: four instances (32b/L1, 32b/L4, 64b/L1, 32b/L5 random delay)
// share one memory model; expected responses go through a scoreboard queue.
module tb_dpic_mem_port;

  typedef struct {
    logic [63:0] rdata;
    logic        wen;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] rdata;
    logic        err;
    int unsigned rd_d;
  } vec_t;

  logic clk;
  logic reset;
  logic        req_valid [4];
  logic        req_wen   [4];
  logic [31:0] req_addr  [4];
  logic [63:0] req_wdata [4];
  logic [7:0]  req_wmask [4];
  logic        resp_ready[4];
  logic        req_ready [4];
  logic        resp_valid[4];
  logic        resp_wen  [4];
  logic        resp_err  [4];
  logic [63:0] resp_rdata[4];
  logic [31:0] rd0, rd1, rd3;
  logic [63:0] rd2;
  logic [7:0]  m_lfsr;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;

  assign resp_rdata[0] = {32'h0, rd0};
  assign resp_rdata[1] = {32'h0, rd1};
  assign resp_rdata[2] = rd2;
  assign resp_rdata[3] = {32'h0, rd3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  dpic_mem_port #(.DATA_W(32), .LATENCY(1)) u_d32 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]),
    .req_wmask(req_wmask[0][3:0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(rd0), .resp_wen(resp_wen[0]), .resp_err(resp_err[0]));

  dpic_mem_port #(.DATA_W(32), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1][31:0]),
    .req_wmask(req_wmask[1][3:0]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(rd1), .resp_wen(resp_wen[1]), .resp_err(resp_err[1]));

  dpic_mem_port #(.DATA_W(64), .LATENCY(1)) u_d64 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wmask(req_wmask[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(rd2), .resp_wen(resp_wen[2]), .resp_err(resp_err[2]));

  dpic_mem_port #(.DATA_W(32), .LATENCY(5), .RAND_DELAY(1)) u_l5r (
    .clk(clk), .reset(reset), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_wen(req_wen[3]), .req_addr(req_addr[3]), .req_wdata(req_wdata[3][31:0]),
    .req_wmask(req_wmask[3][3:0]), .resp_valid(resp_valid[3]), .resp_ready(resp_ready[3]),
    .resp_rdata(rd3), .resp_wen(resp_wen[3]), .resp_err(resp_err[3]));

  // Drive one request and wait for acceptance; req_* are scrambled right after acceptance.
  task automatic issue(input int d, input logic wen, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask,
                       output logic [7:0] lf, output bit ok);
    int cyc = 0;
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
    req_wdata[d] = wdata; req_wmask[d] = wmask;
    while (!req_ready[d] && cyc < 40) begin @(posedge clk); #1; cyc++; end
    ok = req_ready[d];
    lf = m_lfsr;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_wen[d] = ~wen; req_addr[d] = $urandom;
    req_wdata[d] = {$urandom, $urandom}; req_wmask[d] = 8'hFF;
  endtask

  // Wait for the response, optionally stall it for hold cycles, then handshake.
  task automatic collect(input int d, input int hold, output int lat, output logic [63:0] rd,
                         output logic w, output logic e, output bit ok);
    lat = 0; ok = 1'b1;
    while (!resp_valid[d] && lat < 40) begin
      if (req_ready[d]) ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata[d]; w = resp_wen[d]; e = resp_err[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!resp_valid[d] || resp_rdata[d] !== rd || resp_wen[d] !== w ||
          resp_err[d] !== e || req_ready[d]) ok = 1'b0;
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    if (resp_valid[d] || !req_ready[d]) ok = 1'b0;
  endtask

  task automatic xact(input int d, input logic wen, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask, input int hold,
                      output int lat, output logic [7:0] lf, output bit ok,
                      output logic [63:0] rd, output logic w, output logic e);
    bit ok_a, ok_c;
    issue(d, wen, addr, wdata, wmask, lf, ok_a);
    collect(d, hold, lat, rd, w, e, ok_c);
    ok = ok_a && ok_c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if ({req_ready[d], resp_valid[d], resp_wen[d], resp_err[d], resp_rdata[d]} !==
          {4'b1000, 64'h0}) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got rdy=%b vld=%b wen=%b err=%b rd=%h want 1 0 0 0 0",
                 d, req_ready[d], resp_valid[d], resp_wen[d], resp_err[d], resp_rdata[d]);
      end
    end
    n_cmp++;
    if (dpic_mem_pkg::pmem_rd_calls + dpic_mem_pkg::pmem_wr_calls != 0) begin
      n_fail++;
      $display("FAIL reset_no_calls: got %0d calls want 0",
               dpic_mem_pkg::pmem_rd_calls + dpic_mem_pkg::pmem_wr_calls);
    end
  endtask

  task automatic test_write_read();
    exp_t ex; int lat; logic [7:0] lf; bit ok; logic [63:0] rd; logic w, e;
    int unsigned wc = dpic_mem_pkg::pmem_wr_calls;
    int unsigned rc = dpic_mem_pkg::pmem_rd_calls;
    sb_q.push_back('{64'h0, 1'b1, 1'b0});
    xact(0, 1'b1, 32'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err}) begin n_fail++;
      $display("FAIL wr_resp: got %h/%b/%b want %h/%b/%b", rd, w, e, ex.rdata, ex.wen, ex.err); end
    n_cmp++; if (lat !== 1 || !ok) begin n_fail++;
      $display("FAIL wr_latency: got lat=%0d ok=%b want lat=1 ok=1", lat, ok); end
    n_cmp++; if (dpic_mem_pkg::pmem_wr_calls - wc !== 1) begin n_fail++;
      $display("FAIL wr_calls: got %0d want 1", dpic_mem_pkg::pmem_wr_calls - wc); end
    sb_q.push_back('{64'hDEAD_BEEF, 1'b0, 1'b0});
    xact(0, 1'b0, 32'h8000_0010, 64'h0, 8'h0, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err}) begin n_fail++;
      $display("FAIL rd_resp: got %h/%b/%b want %h/%b/%b", rd, w, e, ex.rdata, ex.wen, ex.err); end
    n_cmp++; if (lat !== 1 || !ok || dpic_mem_pkg::pmem_rd_calls - rc !== 1) begin n_fail++;
      $display("FAIL rd_latency_calls: got lat=%0d ok=%b calls=%0d want 1 1 1", lat, ok,
               dpic_mem_pkg::pmem_rd_calls - rc); end
  endtask

  task automatic test_partial_write();
    exp_t ex; int lat; logic [7:0] lf; bit ok; logic [63:0] rd; logic w, e;
    int unsigned wc;
    sb_q.push_back('{64'h0, 1'b1, 1'b0});
    xact(0, 1'b1, 32'h8000_0010, 64'h1234_ABCD, 8'h03, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err}) begin n_fail++;
      $display("FAIL pwr_resp: got %h/%b/%b want %h/%b/%b", rd, w, e, ex.rdata, ex.wen, ex.err); end
    wc = dpic_mem_pkg::pmem_wr_calls;
    sb_q.push_back('{64'h0, 1'b1, 1'b0});
    xact(0, 1'b1, 32'h8000_0010, 64'h0, 8'h00, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err} ||
                 dpic_mem_pkg::pmem_wr_calls !== wc) begin n_fail++;
      $display("FAIL zero_mask: got %h/%b/%b calls=%0d want %h/%b/%b calls=%0d", rd, w, e,
               dpic_mem_pkg::pmem_wr_calls, ex.rdata, ex.wen, ex.err, wc); end
    sb_q.push_back('{64'hDEAD_ABCD, 1'b0, 1'b0});
    xact(0, 1'b0, 32'h8000_0010, 64'h0, 8'h0, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err}) begin n_fail++;
      $display("FAIL pwr_read: got %h/%b/%b want %h/%b/%b", rd, w, e, ex.rdata, ex.wen, ex.err); end
  endtask

  task automatic test_latency_backpressure();
    exp_t ex; int lat; logic [7:0] lf; bit ok; logic [63:0] rd; logic w, e;
    sb_q.push_back('{64'h0, 1'b1, 1'b0});
    xact(1, 1'b1, 32'h8000_0020, 64'hCAFE_F00D, 8'h0F, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err} || lat !== 4) begin n_fail++;
      $display("FAIL l4_write: got %h/%b/%b lat=%0d want %h/%b/%b lat=4", rd, w, e, lat,
               ex.rdata, ex.wen, ex.err); end
    sb_q.push_back('{64'hCAFE_F00D, 1'b0, 1'b0});
    xact(1, 1'b0, 32'h8000_0020, 64'h0, 8'h0, 3, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err}) begin n_fail++;
      $display("FAIL l4_read: got %h/%b/%b want %h/%b/%b", rd, w, e, ex.rdata, ex.wen, ex.err); end
    n_cmp++; if (lat !== 4) begin n_fail++;
      $display("FAIL l4_latency: got %0d want 4", lat); end
    n_cmp++; if (!ok) begin n_fail++;
      $display("FAIL l4_stall_stable: got %b want 1", ok); end
  endtask

  task automatic test_error();
    exp_t ex; int lat; logic [7:0] lf; bit ok; logic [63:0] rd; logic w, e;
    int unsigned rc, wc;
    vec_t tbl[5] = '{
      '{1'b0, 32'h7FFF_FFFC, 64'h0,         1'b1, 0},
      '{1'b0, 32'h8800_0000, 64'h0,         1'b1, 0},
      '{1'b1, 32'h8800_0000, 64'h0,         1'b1, 0},
      '{1'b0, 32'h87FF_FFFC, 64'h0,         1'b0, 1},
      '{1'b0, 32'h8000_0012, 64'hDEAD_ABCD, 1'b0, 1}};
    for (int i = 0; i < 5; i++) begin
      rc = dpic_mem_pkg::pmem_rd_calls;
      wc = dpic_mem_pkg::pmem_wr_calls;
      sb_q.push_back('{tbl[i].rdata, tbl[i].wen, tbl[i].err});
      xact(0, tbl[i].wen, tbl[i].addr, 64'hFFFF_FFFF, 8'h0F, 0, lat, lf, ok, rd, w, e);
      ex = sb_q.pop_front();
      n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err}) begin n_fail++;
        $display("FAIL range[%0d]: got %h/%b/%b want %h/%b/%b", i, rd, w, e,
                 ex.rdata, ex.wen, ex.err); end
      n_cmp++; if (dpic_mem_pkg::pmem_rd_calls - rc !== tbl[i].rd_d ||
                   dpic_mem_pkg::pmem_wr_calls !== wc) begin n_fail++;
        $display("FAIL range_calls[%0d]: got rd=%0d wr=%0d want rd=%0d wr=0", i,
                 dpic_mem_pkg::pmem_rd_calls - rc, dpic_mem_pkg::pmem_wr_calls - wc,
                 tbl[i].rd_d); end
    end
  endtask

  task automatic test_64bit();
    exp_t ex; int lat; logic [7:0] lf; bit ok; logic [63:0] rd; logic w, e;
    int unsigned rc, wc;
    wc = dpic_mem_pkg::pmem_wr_calls;
    sb_q.push_back('{64'h0, 1'b1, 1'b0});
    xact(2, 1'b1, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err} ||
                 dpic_mem_pkg::pmem_wr_calls - wc !== 1) begin n_fail++;
      $display("FAIL w64_hi: got %h/%b/%b calls=%0d want %h/%b/%b calls=1", rd, w, e,
               dpic_mem_pkg::pmem_wr_calls - wc, ex.rdata, ex.wen, ex.err); end
    rc = dpic_mem_pkg::pmem_rd_calls;
    sb_q.push_back('{64'h0123_4567_0000_0000, 1'b0, 1'b0});
    xact(2, 1'b0, 32'h8000_0008, 64'h0, 8'h0, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err} ||
                 dpic_mem_pkg::pmem_rd_calls - rc !== 2) begin n_fail++;
      $display("FAIL r64: got %h/%b/%b calls=%0d want %h/%b/%b calls=2", rd, w, e,
               dpic_mem_pkg::pmem_rd_calls - rc, ex.rdata, ex.wen, ex.err); end
    sb_q.push_back('{64'h0123_4567_0000_0000, 1'b0, 1'b0});
    xact(2, 1'b0, 32'h8000_000C, 64'h0, 8'h0, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err}) begin n_fail++;
      $display("FAIL r64_align: got %h want %h", rd, ex.rdata); end
    wc = dpic_mem_pkg::pmem_wr_calls;
    sb_q.push_back('{64'h0, 1'b1, 1'b0});
    xact(2, 1'b1, 32'h8000_0018, 64'h1122_3344_5566_7788, 8'hFF, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    sb_q.push_back('{64'h1122_3344_5566_7788, 1'b0, 1'b0});
    xact(2, 1'b0, 32'h8000_0018, 64'h0, 8'h0, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err} ||
                 dpic_mem_pkg::pmem_wr_calls - wc !== 2) begin n_fail++;
      $display("FAIL w64_full: got %h calls=%0d want %h calls=2", rd,
               dpic_mem_pkg::pmem_wr_calls - wc, ex.rdata); end
  endtask

  task automatic test_reset_mid_wait();
    exp_t ex; int lat; logic [7:0] lf; bit ok; logic [63:0] rd; logic w, e;
    int unsigned wc = dpic_mem_pkg::pmem_wr_calls;
    issue(3, 1'b1, 32'h8000_0100, 64'h55AA_55AA, 8'h0F, lf, ok);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({req_ready[3], resp_valid[3], resp_wen[3], resp_err[3], resp_rdata[3]} !==
        {4'b1000, 64'h0} || dpic_mem_pkg::pmem_wr_calls !== wc) begin
      n_fail++;
      $display("FAIL mid_wait_reset: got rdy=%b vld=%b wen=%b err=%b rd=%h wr=%0d want 1 0 0 0 0 0",
               req_ready[3], resp_valid[3], resp_wen[3], resp_err[3], resp_rdata[3],
               dpic_mem_pkg::pmem_wr_calls - wc);
    end
    sb_q.push_back('{64'h0, 1'b0, 1'b0});
    xact(3, 1'b0, 32'h8000_0100, 64'h0, 8'h0, 0, lat, lf, ok, rd, w, e);
    ex = sb_q.pop_front();
    n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err} || lat !== 5 + int'(lf[2:0])) begin
      n_fail++;
      $display("FAIL after_reset: got %h/%b/%b lat=%0d want %h/%b/%b lat=%0d", rd, w, e, lat,
               ex.rdata, ex.wen, ex.err, 5 + int'(lf[2:0])); end
  endtask

  task automatic test_rand_delay();
    exp_t ex; int lat; logic [7:0] lf; bit ok; logic [63:0] rd; logic w, e;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      sb_q.push_back('{64'hDEAD_ABCD, 1'b0, 1'b0});
      xact(3, 1'b0, 32'h8000_0010, 64'h0, 8'h0, 0, lat, lf, ok, rd, w, e);
      ex = sb_q.pop_front();
      n_cmp++; if ({rd, w, e} !== {ex.rdata, ex.wen, ex.err} || !ok) begin n_fail++;
        $display("FAIL rand_resp[%0d]: got %h/%b/%b ok=%b want %h/%b/%b ok=1", i, rd, w, e, ok,
                 ex.rdata, ex.wen, ex.err); end
      n_cmp++; if (lat !== 5 + int'(lf[2:0]) || lat < 5 || lat > 12) begin n_fail++;
        $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, 5 + int'(lf[2:0])); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    for (int d = 0; d < 4; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_wmask[d] = '0; resp_ready[d] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_partial_write();
    test_latency_backpressure();
    test_error();
    test_64bit();
    test_reset_mid_wait();
    test_rand_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
